motion_search_engine: RTL

Parametrised full-search block-matching motion estimator. It is the successor to the fixed 16x16 / 32x32 estimator. The block reads a BLK x BLK reference block and a (BLK+2*RANGE)-square search window from external synchronous memories, and computes the sum of absolute differences (SAD) for every candidate displacement. It returns the best distance and a signed motion vector. Unlike the previous generation, it supports configurable block size, search range and pixel width, signed vectors, deterministic tie-breaking, distance saturation, per-candidate early termination and an early-exit threshold. It sits between the frame-buffer memories and the encoder control FSM.

---
 rtl/motion_search_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/motion_search_engine.sv
// motion_search_engine: full-search block-matching motion estimator.
// Walks every (dy,dx) in [-RANGE,+RANGE]^2 in raster order, accumulates the
// saturating SAD of a BLK x BLK reference block against the displaced window
// block and keeps the first strictly-smaller candidate.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   start, thresh       search request; stop once best SAD <= thresh
//                       (thresh all ones never stops early)
//   completed, busy     one-cycle done pulse; search in progress
//   BestDist            best SAD found
//   motionX, motionY    signed best displacement
//   AddressR / R        reference memory port, 1-cycle read latency
//   AddressS / S        search-window memory port, 1-cycle read latency
module motion_search_engine #(
   parameter int PIX_W      = 8,
   parameter int BLK        = 16,
   parameter int RANGE      = 8,
   parameter int DIST_W     = 16,
   parameter int EARLY_TERM = 1,
   localparam int SW        = BLK + 2 * RANGE,
   localparam int AR_W      = $clog2(BLK * BLK),
   localparam int AS_W      = $clog2(SW * SW),
   localparam int MV_W      = $clog2(RANGE + 1) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIST_W-1:0] thresh,
   output logic              completed,
   output logic              busy,
   output logic [DIST_W-1:0] BestDist,
   output logic [MV_W-1:0]   motionX,
   output logic [MV_W-1:0]   motionY,
   output logic [AR_W-1:0]   AddressR,
   input  logic [PIX_W-1:0]  R,
   output logic [AS_W-1:0]   AddressS,
   input  logic [PIX_W-1:0]  S
);

   localparam int NPIX    = BLK * BLK;
   localparam int PXW     = $clog2(BLK);
   localparam int OW      = $clog2(2 * RANGE + 1);
   localparam int LASTOFF = 2 * RANGE;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} stateT;

   stateT state, nextState;

   logic [AR_W-1:0]     pixIdx;
   logic [OW-1:0]       offX, offY;
   logic [DIST_W-1:0]   acc;
   logic [PIX_W-1:0]    diffReg;
   logic                rdValid, diffValid, drainCnt, haveBest;

   logic                lastPix, etHit, lastCand, better, threshHit;
   logic [DIST_W-1:0]   candBest;
   logic [DIST_W:0]     sum;
   logic [DIST_W-1:0]   accSat;
   logic [OW-1:0]       advX, advY, issOffX, issOffY;
   logic [AR_W-1:0]     issueIdx;
   logic [AR_W-PXW-1:0] issPy;
   logic [PXW-1:0]      issPx;
   logic [AS_W-1:0]     sAddr;

   always_comb begin
      lastPix   = (pixIdx == AR_W'(NPIX - 1));
      // A partial SAD already at the best can never win, so stop reading.
      etHit     = (EARLY_TERM != 0) && haveBest && (acc >= BestDist);
      lastCand  = (offX == OW'(LASTOFF)) && (offY == OW'(LASTOFF));
      better    = !haveBest || (acc < BestDist);
      candBest  = better ? acc : BestDist;
      threshHit = (thresh != '1) && (candBest <= thresh);

      sum    = {1'b0, acc} + (DIST_W + 1)'(diffReg);
      accSat = sum[DIST_W] ? '1 : sum[DIST_W-1:0];

      advX = (offX == OW'(LASTOFF)) ? '0 : offX + OW'(1);
      advY = (offX == OW'(LASTOFF)) ? offY + OW'(1) : offY;

      // Address for the pixel presented in the next cycle.
      issueIdx = '0;
      issOffX  = offX;
      issOffY  = offY;
      unique case (state)
         IDLE: begin
            issOffX = '0;
            issOffY = '0;
         end
         RUN:  issueIdx = pixIdx + AR_W'(1);
         CMP: begin
            issOffX = advX;
            issOffY = advY;
         end
         default: ;
      endcase
      issPy = issueIdx[AR_W-1:PXW];
      issPx = issueIdx[PXW-1:0];
      sAddr = (AS_W'(issPy) + AS_W'(issOffY)) * AS_W'(SW)
            + AS_W'(issPx) + AS_W'(issOffX);
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (lastPix || etHit) nextState = DRAIN;
         DRAIN:   if (drainCnt) nextState = CMP;
         CMP:     nextState = (lastCand || threshHit) ? DONE : RUN;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         completed <= 1'b0;
         busy      <= 1'b0;
         BestDist  <= '0;
         motionX   <= '0;
         motionY   <= '0;
         AddressR  <= '0;
         AddressS  <= '0;
         pixIdx    <= '0;
         offX      <= '0;
         offY      <= '0;
         acc       <= '0;
         diffReg   <= '0;
         rdValid   <= 1'b0;
         diffValid <= 1'b0;
         drainCnt  <= 1'b0;
         haveBest  <= 1'b0;
      end else begin
         state     <= nextState;
         completed <= (state == DONE);
         busy      <= (nextState != IDLE) || (state == DONE);
         // Two-stage read pipe: data returns, then |R-S| is registered.
         rdValid   <= (state == RUN);
         diffValid <= rdValid;
         diffReg   <= (R > S) ? R - S : S - R;
         drainCnt  <= (state == DRAIN) ? ~drainCnt : 1'b0;

         if ((state == IDLE && start) || (state == CMP && nextState == RUN))
            acc <= '0;
         else if (diffValid)
            acc <= accSat;

         unique case (state)
            IDLE: if (start) begin
               pixIdx   <= '0;
               offX     <= '0;
               offY     <= '0;
               haveBest <= 1'b0;
               AddressR <= '0;
               AddressS <= sAddr;
            end
            RUN: if (nextState == RUN) begin
               pixIdx   <= issueIdx;
               AddressR <= issueIdx;
               AddressS <= sAddr;
            end
            CMP: begin
               if (better) begin
                  BestDist <= acc;
                  motionX  <= MV_W'(offX) - MV_W'(RANGE);
                  motionY  <= MV_W'(offY) - MV_W'(RANGE);
                  haveBest <= 1'b1;
               end
               if (nextState == RUN) begin
                  offX     <= advX;
                  offY     <= advY;
                  pixIdx   <= '0;
                  AddressR <= '0;
                  AddressS <= sAddr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
